// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - branch type encodings, redirect FSM states and alignment helper
package branch_pkg;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b010,
      BGE  = 3'b011,
      BLTU = 3'b100,
      BGEU = 3'b101,
      ILL  = 3'b110,
      JMP  = 3'b111
   } br_type_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      FLUSH = 2'd2
   } redir_state_e;

   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic logic is_aligned(input logic [1:0] lsb);
      return (lsb & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/branch_perf_cnt.sv
// rtl/branch_perf_cnt.sv - wrapping resolved-branch and issued-redirect counters
module branch_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_branch,
   input  logic             inc_taken,
   output logic [CNT_W-1:0] perf_branches,
   output logic [CNT_W-1:0] perf_taken
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branches <= '0;
         perf_taken    <= '0;
      end else begin
         if (inc_branch) perf_branches <= perf_branches + 1'b1;
         if (inc_taken)  perf_taken    <= perf_taken + 1'b1;
      end
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - PC redirect / IF flush sequencer; BRANCH_PERF_EN adds perf counters
module branch_redirect_ctrl
   import branch_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [2:0]      ex_br_type,
   input  logic            br_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            stall_in,
   input  logic            if_ready,
   output logic            pc_sel,
   output logic [XLEN-1:0] pc_target,
   output logic            flush_if,
   output logic            misalign_o,
   output logic [XLEN-1:0] misalign_pc,
   output logic            illegal_br
`ifdef BRANCH_PERF_EN
   ,output logic [CNT_W-1:0] perf_branches
   ,output logic [CNT_W-1:0] perf_taken
`endif
);

   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) + 1 : 1;

   redir_state_e    state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] tgt_q;

   logic br_ok, is_ill, cand, aligned, take, misal;

   // rst_n gates the decode so the redirect outputs stay 0 while reset is held
   assign br_ok   = rst_n & (state == IDLE) & ex_valid & ex_is_branch & ~stall_in;
   assign is_ill  = (br_type_e'(ex_br_type) == ILL);
   assign cand    = br_ok & br_taken & ~is_ill;
   assign aligned = is_aligned(ex_target[1:0]);
   assign take    = cand & aligned;
   assign misal   = cand & ~aligned;

   always_comb begin
      pc_sel    = 1'b0;
      pc_target = '0;
      flush_if  = 1'b0;
      case (state)
         IDLE: begin
            if (take) begin
               pc_sel    = 1'b1;
               pc_target = ex_target;
               flush_if  = 1'b1;
            end
         end
         PEND: begin
            pc_sel    = 1'b1;
            pc_target = tgt_q;
            flush_if  = 1'b1;
         end
         FLUSH:   flush_if = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         tgt_q       <= '0;
         misalign_o  <= 1'b0;
         misalign_pc <= '0;
         illegal_br  <= 1'b0;
      end else begin
         misalign_o <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  tgt_q <= ex_target;
                  if (!if_ready) begin
                     state <= PEND;
                  end else if (FLUSH_CYCLES > 1) begin
                     state <= FLUSH;
                     cnt   <= CW'(FLUSH_CYCLES - 1);
                  end
               end
               if (misal) begin
                  misalign_o  <= 1'b1;
                  misalign_pc <= ex_pc;
               end
               if (br_ok && is_ill) illegal_br <= 1'b1;
            end
            PEND: begin
               if (if_ready) begin
                  if (FLUSH_CYCLES > 1) begin
                     state <= FLUSH;
                     cnt   <= CW'(FLUSH_CYCLES - 1);
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            FLUSH: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BRANCH_PERF_EN
   branch_perf_cnt #(.CNT_W(CNT_W)) u_perf (
      .clk           (clk),
      .rst_n         (rst_n),
      .inc_branch    (br_ok),
      .inc_taken     (take),
      .perf_branches (perf_branches),
      .perf_taken    (perf_taken)
   );
`endif

endmodule
